// File: rtl/ram_arbiter.sv
// Two-port RAM arbiter: CPU vs loader, round-robin on ties,
// loader burst lock bounded by BURST_MAX with forced CPU slots.
module ram_arbiter #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4,
   parameter int BURST_MAX  = 16
) (
   input  logic                  i_CLOCK,
   input  logic                  i_RESET_n,
   input  logic                  i_CPU_REQ,
   input  logic                  i_CPU_WE,
   input  logic [ADDR_WIDTH-1:0] i_CPU_ADDR,
   input  logic [DATA_WIDTH-1:0] i_CPU_WDATA,
   input  logic                  i_LD_REQ,
   input  logic                  i_LD_WE,
   input  logic [ADDR_WIDTH-1:0] i_LD_ADDR,
   input  logic [DATA_WIDTH-1:0] i_LD_WDATA,
   input  logic                  i_LD_LOCK,
   output logic                  o_CPU_GNT,
   output logic                  o_LD_GNT,
   output logic                  o_CPU_RVALID,
   output logic                  o_LD_RVALID,
   output logic [ADDR_WIDTH-1:0] o_RAM_ADDR,
   output logic [DATA_WIDTH-1:0] o_RAM_WDATA,
   output logic                  o_RAM_WE,
   output logic                  o_CPU_STALL
);

   localparam int CW = $clog2(BURST_MAX + 1);
   localparam logic [CW-1:0] BMAX = CW'(BURST_MAX);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CPU  = 2'd1,
      LDR  = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_next;
   logic                  r_last_ld;
   logic [CW-1:0]         r_burst;
   logic                  r_cpu_gnt;
   logic                  r_ld_gnt;
   logic                  r_cpu_rvalid;
   logic                  r_ld_rvalid;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic                  r_we;

   // Lock overrides round-robin until the burst is exhausted
   always_comb begin
      w_next = IDLE;
      if (i_LD_LOCK && i_LD_REQ) begin
         if (r_burst == BMAX && i_CPU_REQ)
            w_next = CPU;
         else
            w_next = LDR;
      end else if (i_CPU_REQ && i_LD_REQ) begin
         w_next = r_last_ld ? CPU : LDR;
      end else if (i_CPU_REQ) begin
         w_next = CPU;
      end else if (i_LD_REQ) begin
         w_next = LDR;
      end
   end

   always_ff @(posedge i_CLOCK or negedge i_RESET_n) begin
      if (!i_RESET_n) begin
         r_state      <= IDLE;
         r_last_ld    <= 1'b1;
         r_burst      <= '0;
         r_cpu_gnt    <= 1'b0;
         r_ld_gnt     <= 1'b0;
         r_cpu_rvalid <= 1'b0;
         r_ld_rvalid  <= 1'b0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_we         <= 1'b0;
      end else begin
         r_state      <= w_next;
         r_cpu_gnt    <= (w_next == CPU);
         r_ld_gnt     <= (w_next == LDR);
         r_cpu_rvalid <= (r_state == CPU) && !r_we;
         r_ld_rvalid  <= (r_state == LDR) && !r_we;
         r_we         <= 1'b0;
         case (w_next)
            CPU: begin
               r_addr    <= i_CPU_ADDR;
               r_wdata   <= i_CPU_WDATA;
               r_we      <= i_CPU_WE;
               r_last_ld <= 1'b0;
            end
            LDR: begin
               r_addr    <= i_LD_ADDR;
               r_wdata   <= i_LD_WDATA;
               r_we      <= i_LD_WE;
               r_last_ld <= 1'b1;
            end
            default: ;
         endcase
         if (!i_LD_LOCK || w_next == CPU)
            r_burst <= '0;
         else if (w_next == LDR && r_burst != BMAX)
            r_burst <= r_burst + 1'b1;
      end
   end

   assign o_CPU_GNT    = r_cpu_gnt;
   assign o_LD_GNT     = r_ld_gnt;
   assign o_CPU_RVALID = r_cpu_rvalid;
   assign o_LD_RVALID  = r_ld_rvalid;
   assign o_RAM_ADDR   = r_addr;
   assign o_RAM_WDATA  = r_wdata;
   assign o_RAM_WE     = r_we;
   assign o_CPU_STALL  = (i_CPU_REQ && r_state != CPU) || i_LD_LOCK;

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameters: DATA_WIDTH, 8, RAM word width; ADDR_WIDTH, 4, RAM address width; BURST_MAX, 16, maximum consecutive loader grants under lock.
REQ-002 SHALL have ports (name  direction  width  meaning):
- i_CLOCK  in  1  single clock; all state updates on posedge.
- i_RESET_n  in  1  asynchronous, active-low reset.
- i_CPU_REQ  in  1  CPU access request; held until granted.
- i_CPU_WE  in  1  CPU write (1) / read (0).
- i_CPU_ADDR  in  ADDR_WIDTH  CPU address.
- i_CPU_WDATA  in  DATA_WIDTH  CPU write data.
- i_LD_REQ  in  1  loader access request; held until granted.
- i_LD_WE  in  1  loader write (1) / read (0).
- i_LD_ADDR  in  ADDR_WIDTH  loader address.
- i_LD_WDATA  in  DATA_WIDTH  loader write data.
- i_LD_LOCK  in  1  loader burst lock.
- o_CPU_GNT  out  1  CPU access performed this cycle.
- o_LD_GNT  out  1  loader access performed this cycle.
- o_CPU_RVALID  out  1  RAM read data belongs to CPU.
- o_LD_RVALID  out  1  RAM read data belongs to loader.
- o_RAM_ADDR  out  ADDR_WIDTH  RAM address.
- o_RAM_WDATA  out  DATA_WIDTH  RAM write data.
- o_RAM_WE  out  1  RAM write enable.
- o_CPU_STALL  out  1  freezes the control-unit T-cycle counter.
REQ-003 SHALL use one clock and an asynchronous, active-low reset, named i_CLOCK and i_RESET_n.

Function
REQ-004 SHALL implement FSM states IDLE, CPU, LDR, and SHALL update state, grants and all o_RAM_* outputs as registers at posedge i_CLOCK.
REQ-005 SHALL select the next state from requests sampled at each posedge: no request -> IDLE; single requester -> that requester; both requesting -> round-robin, opposite of the last granted requester.
REQ-006 SHALL assert o_CPU_GNT only in CPU and o_LD_GNT only in LDR, each for exactly one cycle per access; a requester still requesting after its grant cycle is treated as a new request.
REQ-007 SHALL drive o_RAM_ADDR, o_RAM_WDATA and o_RAM_WE from the granted requester's captured inputs during the grant cycle; in IDLE o_RAM_WE=0 and address/data hold their last values.
REQ-008 SHALL, for a granted read, assert the matching *_RVALID for exactly the one cycle following the grant cycle, and never for writes.
REQ-009 SHALL, while i_LD_LOCK=1 and i_LD_REQ=1, grant the loader on consecutive cycles regardless of round-robin, counting grants in a burst counter.
REQ-010 SHALL, when the burst counter reaches BURST_MAX with i_CPU_REQ=1, grant the CPU for one cycle, then clear the counter; with i_CPU_REQ=0 the counter saturates and the loader continues.
REQ-011 SHALL clear the burst counter whenever i_LD_LOCK=0 or a CPU grant occurs.
REQ-012 SHALL assert o_CPU_STALL combinationally whenever i_CPU_REQ=1 and the current state is not CPU, and whenever i_LD_LOCK=1.
REQ-013 SHALL keep the round-robin pointer unchanged across IDLE cycles.

Reset
REQ-014 SHALL, while i_RESET_n=0, force IDLE, all grants and RVALIDs 0, o_RAM_WE=0, o_RAM_ADDR=0, o_RAM_WDATA=0, burst counter 0, and round-robin pointer "last=LDR", so the CPU wins the first tie.
REQ-015 SHALL abort any in-flight access on reset assertion mid-grant: the write does not complete past reset and the pending RVALID is not issued.

Verification
REQ-016 Single CPU write, addr 0x3, data 0xA5 -> o_CPU_GNT=1 for one cycle with o_RAM_WE=1, ADDR=0x3, WDATA=0xA5; STALL deasserts after the grant.
REQ-017 Simultaneous CPU/loader reads held 4 cycles after reset -> grants alternate CPU, LDR, CPU, LDR; each RVALID one cycle after its grant.
REQ-018 Loader lock with continuous writes and CPU requesting -> 16 consecutive LD grants, 1 CPU grant, then loader resumes; o_CPU_STALL=1 throughout the burst.
REQ-019 Loader lock with CPU idle for 40 cycles -> 40 consecutive LD grants, no CPU grant, counter saturated at 16.
REQ-020 i_RESET_n pulsed low during a CPU read grant -> outputs at reset values immediately, no o_CPU_RVALID; the first tie after reset goes to the CPU.
REQ-021 No requests for 10 cycles -> IDLE, o_RAM_WE=0, no grants, pointer unchanged.
